// File: rtl/fazyrv_seq.sv
// fazyrv_seq - instruction control sequencer for the bit/chunk-serial FazyRV core.
//
// Each instruction is split into passes: instruction fetch, register-file
// decode (RF_RD_LAT+1 cycles), then one or two serial CPI-cycle passes over
// the datapath. Loads and stores add a data-bus ACK phase; shifts may add a
// SHIFT phase. A bus that does not answer within MEM_TIMEOUT cycles raises a
// one-cycle bus error and runs a single TRAP pass before the next fetch.
//
// Ports
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   abort_i             abort current instruction (only when HAS_ABORT=1)
//   pc_noinc_i          suppress PC increment (only when HAS_ABORT=1)
//   cls_i[6:0]          instruction class {csr,slt,shft,st,ld,br,jmp}
//   shft_done_i         shifter has finished its macro-steps
//   imem_ack_i          instruction bus ack (ignored when MEMDLY1=1)
//   dmem_ack_i          data bus ack
//   ccx_done_i          custom unit done
//   imem_stb_o          instruction bus strobe (IFETCH)
//   dmem_stb_o          data bus strobe (ACK)
//   rf_ram_rstb_o       RF RAM read strobe (DECODE, RF_RD_LAT>0)
//   rf_ram_wstb_o       RF RAM write strobe (RF_RD_LAT>0)
//   lsb_o, msb_o        first / last chunk of the current pass
//   pc_inc_o            increment PC this cycle
//   ccx_req_o           start custom instruction
//   cyc_two_o, cyc_ack_o, cyc_shft_o, cyc_trap_o   state flags
//   bus_err_o           one-cycle pulse on bus timeout
//   hlt_regs_o, hlt_spm_a_o, hlt_imm_o             datapath halts
//   icyc_o              chunk index within the current pass

module fazyrv_seq #(
    parameter int unsigned CHUNKSIZE   = 2,
    parameter int unsigned REG_WIDTH   = 32,
    parameter int unsigned CPI         = REG_WIDTH / CHUNKSIZE,
    parameter int unsigned RF_RD_LAT   = 0,
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned HAS_ABORT   = 0,
    parameter int unsigned MEMDLY1     = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   abort_i,
    input  logic                   pc_noinc_i,
    input  logic [6:0]             cls_i,
    input  logic                   shft_done_i,
    input  logic                   imem_ack_i,
    input  logic                   dmem_ack_i,
    input  logic                   ccx_done_i,
    output logic                   imem_stb_o,
    output logic                   dmem_stb_o,
    output logic                   rf_ram_rstb_o,
    output logic                   rf_ram_wstb_o,
    output logic                   lsb_o,
    output logic                   msb_o,
    output logic                   pc_inc_o,
    output logic                   ccx_req_o,
    output logic                   cyc_two_o,
    output logic                   cyc_ack_o,
    output logic                   cyc_shft_o,
    output logic                   cyc_trap_o,
    output logic                   bus_err_o,
    output logic                   hlt_regs_o,
    output logic                   hlt_spm_a_o,
    output logic                   hlt_imm_o,
    output logic [$clog2(CPI)-1:0] icyc_o
);

    localparam int unsigned CYC_W  = $clog2(CPI);
    localparam int unsigned DCNT_W = (RF_RD_LAT > 0) ? $clog2(RF_RD_LAT + 1) : 1;
    localparam int unsigned TMO_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam bit ABORT_EN  = (HAS_ABORT != 0);
    localparam bit RF_LAT_EN = (RF_RD_LAT != 0);
    localparam bit TMO_EN    = (MEM_TIMEOUT != 0);
    localparam bit IMEM_FIX  = (MEMDLY1 != 0);

    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CPI - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(RF_RD_LAT);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IFETCH,
        DECODE,
        ICYC1,
        ICYC2,
        ACK,
        SHIFT,
        TRAP
    } state_t;

    state_t              state, state_nxt;
    logic [CYC_W-1:0]    cyc, cyc_nxt, cyc_inc;
    logic [DCNT_W-1:0]   dcnt, dcnt_nxt;
    logic [TMO_W-1:0]    tmo, tmo_nxt;
    logic                lsb_r;
    logic                msb;
    logic                bus_err;

    logic                csr, slt, shft, st, ld, br, jmp;
    logic                abort, noinc, imem_ack;
    logic                cyc_last, dcnt_last, tmo_last;
    logic                in_c1, in_c2, in_bus;

    assign {csr, slt, shft, st, ld, br, jmp} = cls_i;

    assign abort     = ABORT_EN & abort_i;
    assign noinc     = ABORT_EN & pc_noinc_i;
    assign imem_ack  = imem_ack_i | IMEM_FIX;
    assign cyc_last  = (cyc == CYC_LAST);
    assign dcnt_last = (dcnt == DCNT_LAST);
    assign tmo_last  = TMO_EN & (tmo == TMO_LAST);
    assign cyc_inc   = cyc_last ? '0 : cyc + CYC_W'(1);
    assign in_c1     = (state == ICYC1);
    assign in_c2     = (state == ICYC2);
    assign in_bus    = (state == IFETCH) | (state == ACK);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IFETCH;
            cyc   <= '0;
            dcnt  <= '0;
            tmo   <= '0;
            lsb_r <= 1'b1;
        end else begin
            state <= state_nxt;
            cyc   <= cyc_nxt;
            dcnt  <= dcnt_nxt;
            tmo   <= tmo_nxt;
            lsb_r <= msb;
        end
    end

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc;
        dcnt_nxt  = '0;
        msb       = 1'b0;
        bus_err   = 1'b0;

        case (state)
            IFETCH: begin
                msb     = 1'b1;
                cyc_nxt = '0;
                if (imem_ack) begin
                    state_nxt = DECODE;
                end else if (tmo_last && !abort) begin
                    bus_err   = 1'b1;
                    state_nxt = TRAP;
                end
            end

            DECODE: begin
                msb     = 1'b1;
                cyc_nxt = '0;
                if (dcnt_last) begin
                    state_nxt = ICYC1;
                end else begin
                    dcnt_nxt = dcnt + DCNT_W'(1);
                end
            end

            ICYC1: begin
                if (!cyc_last) begin
                    cyc_nxt = cyc + CYC_W'(1);
                end else if (ccx_done_i) begin
                    // Last chunk only completes once the custom unit is done;
                    // until then cyc parks on CPI-1.
                    msb     = 1'b1;
                    cyc_nxt = '0;
                    if (abort) begin
                        state_nxt = IFETCH;
                    end else if (shft) begin
                        state_nxt = shft_done_i ? ICYC2 : SHIFT;
                    end else if (ld) begin
                        state_nxt = ACK;
                    end else if (jmp | br | st | slt | csr) begin
                        state_nxt = ICYC2;
                    end else begin
                        state_nxt = IFETCH;
                    end
                end
            end

            ICYC2: begin
                cyc_nxt = cyc_inc;
                if (cyc_last) begin
                    msb       = 1'b1;
                    state_nxt = st ? ACK : IFETCH;
                end
            end

            SHIFT: begin
                cyc_nxt = '0;
                if (shft_done_i) begin
                    msb       = 1'b1;
                    state_nxt = ICYC2;
                end
            end

            ACK: begin
                cyc_nxt = '0;
                msb     = dmem_ack_i;
                if (abort) begin
                    state_nxt = IFETCH;
                end else if (dmem_ack_i) begin
                    if (ld) begin
                        state_nxt = shft_done_i ? ICYC2 : SHIFT;
                    end else begin
                        state_nxt = IFETCH;
                    end
                end else if (tmo_last) begin
                    bus_err   = 1'b1;
                    state_nxt = TRAP;
                end
            end

            TRAP: begin
                cyc_nxt = cyc_inc;
                if (cyc_last) begin
                    msb       = 1'b1;
                    state_nxt = IFETCH;
                end
            end

            default: begin
                state_nxt = IFETCH;
                cyc_nxt   = '0;
            end
        endcase

        // Timeout only runs while waiting on a bus in the same state; any
        // transition (ack, error, abort) restarts it from zero.
        if (TMO_EN && in_bus && (state_nxt == state) && !abort) begin
            tmo_nxt = tmo + TMO_W'(1);
        end else begin
            tmo_nxt = '0;
        end
    end

    always_comb begin
        imem_stb_o    = (state == IFETCH);
        dmem_stb_o    = (state == ACK);
        rf_ram_rstb_o = RF_LAT_EN & (state == DECODE);
        rf_ram_wstb_o = RF_LAT_EN & ((state == IFETCH) | (in_c2 & lsb_r & csr));
        lsb_o         = lsb_r;
        msb_o         = msb;
        pc_inc_o      = lsb_r & ~noinc & ((br | ld | st) ? in_c2 : in_c1);
        ccx_req_o     = in_c1 & lsb_r;
        cyc_two_o     = in_c2;
        cyc_ack_o     = (state == ACK);
        cyc_shft_o    = (state == SHIFT);
        cyc_trap_o    = (state == TRAP);
        bus_err_o     = bus_err;
        hlt_regs_o    = ~(in_c1 | in_c2);
        hlt_spm_a_o   = ~(in_c1 & ~(shft & msb));
        hlt_imm_o     = in_c1 ? br : ~in_c2;
        icyc_o        = cyc;
    end

endmodule
